sentinel_seq_lock: RTL and testbench

//  Parametrised multi-byte successor to the single-byte Sentinel gate.
//  - Accepts a KEY_BYTES-long key one byte per strobe and tracks failed attempts.
//  - Enforces a timed lockout after MAX_FAILS failures.
//  - Drives the 7-segment display and the glow status array.
//  - Sits between the DIP-switch key interface and the display/status pins of the top wrapper.

---
 rtl/sentinel_seq_lock.sv | 215 +++++++++++++++++++++
 tb/tb_sentinel_seq_lock.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sentinel_seq_lock.sv
// ============================================================================
// Module   : sentinel_seq_lock
// Purpose  : Multi-byte key lock with failed-attempt tracking, timed lockout,
//            7-segment status display and glow array drive.
// Options  : SENTINEL_AUTO_RELOCK_EN - leave UNLOCKED after RELOCK_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sentinel_seq_lock #(
    parameter int                    KEY_BYTES      = 2,
    parameter logic [KEY_BYTES*8-1:0] KEY           = 16'h5AB6,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 1024,
    parameter int                    ENTRY_TIMEOUT  = 256,
    parameter int                    RELOCK_CYCLES  = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [7:0]                       key_byte,
    input  logic                             key_valid,
    input  logic                             relock,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [7:0]                       seg_out,
    output logic [7:0]                       glow
);

    localparam int c_FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int c_IDX_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int c_TMR_W  = $clog2(ENTRY_TIMEOUT);
    // Lockout counter is at least 7 bits so bit 6 can drive the dp blink.
    localparam int c_LCK_W  = ($clog2(LOCKOUT_CYCLES) > 7) ? $clog2(LOCKOUT_CYCLES) : 7;

    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(KEY_BYTES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMO_LAST  = c_TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [c_LCK_W-1:0]  c_LCK_LAST  = c_LCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_LAST = c_FAIL_W'(MAX_FAILS - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX  = c_FAIL_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_ENTRY    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_IDX_W-1:0]  idx_q,   idx_d;
    logic                mism_q,  mism_d;
    logic [c_TMR_W-1:0]  tmr_q,   tmr_d;
    logic [c_LCK_W-1:0]  lck_q,   lck_d;
    logic [c_FAIL_W-1:0] fail_q,  fail_d;

    logic w_end;
    logic w_bad;
    logic w_bad_now;

`ifdef SENTINEL_AUTO_RELOCK_EN
    localparam int c_RLK_W = ($clog2(RELOCK_CYCLES) > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam logic [c_RLK_W-1:0] c_RLK_LAST = c_RLK_W'(RELOCK_CYCLES - 1);

    logic [c_RLK_W-1:0] rlk_q, rlk_d;
`else
    logic w_unused_relock;
    assign w_unused_relock = |RELOCK_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mism_d    = mism_q;
        tmr_d     = tmr_q;
        lck_d     = lck_q;
        fail_d    = fail_q;
        w_end     = 1'b0;
        w_bad     = 1'b0;
        w_bad_now = 1'b0;
`ifdef SENTINEL_AUTO_RELOCK_EN
        rlk_d     = '0;
`endif

        if (ena) begin
            case (state_q)
                S_LOCKED: begin
                    if (key_valid) begin
                        if (KEY_BYTES == 1) begin
                            w_end = 1'b1;
                            w_bad = (key_byte != KEY[7:0]);
                        end else begin
                            state_d = S_ENTRY;
                            idx_d   = c_IDX_W'(1);
                            mism_d  = (key_byte != KEY[7:0]);
                            tmr_d   = '0;
                        end
                    end
                end
                S_ENTRY: begin
                    // A strobe on the timeout cycle still counts as a byte.
                    if (key_valid) begin
                        tmr_d     = '0;
                        w_bad_now = mism_q | (key_byte != KEY[idx_q*8 +: 8]);
                        if (idx_q == c_LAST_IDX) begin
                            w_end = 1'b1;
                            w_bad = w_bad_now;
                        end else begin
                            idx_d  = idx_q + c_IDX_W'(1);
                            mism_d = w_bad_now;
                        end
                    end else if (tmr_q == c_TMO_LAST) begin
                        w_end = 1'b1;
                        w_bad = 1'b1;
                    end else begin
                        tmr_d = tmr_q + c_TMR_W'(1);
                    end
                end
                S_UNLOCKED: begin
                    if (relock) begin
                        state_d = S_LOCKED;
                    end
`ifdef SENTINEL_AUTO_RELOCK_EN
                    else if (rlk_q == c_RLK_LAST) begin
                        state_d = S_LOCKED;
                    end else begin
                        rlk_d = rlk_q + c_RLK_W'(1);
                    end
`endif
                end
                S_LOCKOUT: begin
                    if (lck_q == c_LCK_LAST) begin
                        state_d = S_LOCKED;
                        fail_d  = '0;
                        lck_d   = '0;
                    end else begin
                        lck_d = lck_q + c_LCK_W'(1);
                    end
                end
                default: state_d = S_LOCKED;
            endcase

            if (w_end) begin
                idx_d  = '0;
                mism_d = 1'b0;
                tmr_d  = '0;
                if (!w_bad) begin
                    state_d = S_UNLOCKED;
                    fail_d  = '0;
                end else if (fail_q == c_FAIL_LAST) begin
                    state_d = S_LOCKOUT;
                    fail_d  = c_FAIL_MAX;
                    lck_d   = '0;
                end else begin
                    state_d = S_LOCKED;
                    fail_d  = fail_q + c_FAIL_W'(1);
                end
            end
        end
`ifdef SENTINEL_AUTO_RELOCK_EN
        else begin
            rlk_d = rlk_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOCKED;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            tmr_q   <= '0;
            lck_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            tmr_q   <= tmr_d;
            lck_q   <= lck_d;
            fail_q  <= fail_d;
        end
    end

`ifdef SENTINEL_AUTO_RELOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rlk_q <= '0;
        end else begin
            rlk_q <= rlk_d;
        end
    end
`endif

    assign unlocked   = (state_q == S_UNLOCKED);
    assign locked_out = (state_q == S_LOCKOUT);
    assign fail_count = fail_q;
    assign glow       = (ena && state_q == S_UNLOCKED) ? 8'hFF : 8'h00;

    always_comb begin
        seg_out = 8'hFF;
        if (ena) begin
            case (state_q)
                S_LOCKED:   seg_out = 8'hC7;
                S_ENTRY:    seg_out = 8'hBF;
                S_UNLOCKED: seg_out = 8'hC1;
                S_LOCKOUT:  seg_out = {~lck_q[6], 7'h06};
                default:    seg_out = 8'hFF;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sentinel_seq_lock.sv
// ============================================================================
// Module   : tb_sentinel_seq_lock
// Purpose  : Directed self-checking bench for sentinel_seq_lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sentinel_seq_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] key_byte;
    logic       key_valid;
    logic       relock;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [7:0] seg_out;
    logic [7:0] glow;

    int checks = 0;
    int errors = 0;

    sentinel_seq_lock dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .key_byte   (key_byte),
        .key_valid  (key_valid),
        .relock     (relock),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .seg_out    (seg_out),
        .glow       (glow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        key_byte  = b;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        key_byte  = 8'h00;
    endtask

    task automatic do_relock();
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; key_byte = 8'h00; key_valid = 1'b0; relock = 1'b0;
        tick(2);
        checks++; if (seg_out !== 8'hC7) begin errors++; $display("FAIL reset_seg got %h exp c7", seg_out); end
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked got %b exp 0", unlocked); end
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked_out got %b exp 0", locked_out); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail got %0d exp 0", fail_count); end
        checks++; if (glow !== 8'h00) begin errors++; $display("FAIL reset_glow got %h exp 00", glow); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_unlock();
        strobe(8'hB6);
        checks++; if (seg_out !== 8'hBF) begin errors++; $display("FAIL unlock_entry_seg got %h exp bf", seg_out); end
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL unlock_early got %b exp 0", unlocked); end
        strobe(8'h5A);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_flag got %b exp 1", unlocked); end
        checks++; if (seg_out !== 8'hC1) begin errors++; $display("FAIL unlock_seg got %h exp c1", seg_out); end
        checks++; if (glow !== 8'hFF) begin errors++; $display("FAIL unlock_glow got %h exp ff", glow); end
    endtask

    task automatic test_relock_priority();
        strobe(8'h00);
        checks++; if (seg_out !== 8'hC1) begin errors++; $display("FAIL unlocked_ignores_key got %h exp c1", seg_out); end
        relock = 1'b1; key_valid = 1'b1; key_byte = 8'hB6;
        tick(1);
        relock = 1'b0; key_valid = 1'b0;
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_flag got %b exp 0", unlocked); end
        tick(1);
        checks++; if (seg_out !== 8'hC7) begin errors++; $display("FAIL relock_no_entry got %h exp c7", seg_out); end
    endtask

    task automatic test_lockout();
        strobe(8'hB6); strobe(8'h00);
        checks++; if (fail_count !== 2'd1) begin errors++; $display("FAIL lockout_fail1 got %0d exp 1", fail_count); end
        checks++; if (seg_out !== 8'hC7) begin errors++; $display("FAIL lockout_seg1 got %h exp c7", seg_out); end
        strobe(8'hB6); strobe(8'h00);
        checks++; if (fail_count !== 2'd2) begin errors++; $display("FAIL lockout_fail2 got %0d exp 2", fail_count); end
        strobe(8'hB6); strobe(8'h00);
        checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lockout_flag got %b exp 1", locked_out); end
        checks++; if (seg_out !== 8'h86) begin errors++; $display("FAIL lockout_seg got %h exp 86", seg_out); end
        // Keys are ignored; lockout counter now at 2.
        strobe(8'hB6); strobe(8'h5A);
        checks++; if (unlocked !== 1'b0 || locked_out !== 1'b1) begin errors++; $display("FAIL lockout_ignores_key got u=%b lo=%b exp u=0 lo=1", unlocked, locked_out); end
        tick(98);
        checks++; if (seg_out !== 8'h06) begin errors++; $display("FAIL lockout_dp_blink got %h exp 06", seg_out); end
        tick(923);
        checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lockout_hold_1023 got %b exp 1", locked_out); end
        tick(1);
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lockout_exit got %b exp 0", locked_out); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL lockout_fail_clear got %0d exp 0", fail_count); end
        checks++; if (seg_out !== 8'hC7) begin errors++; $display("FAIL lockout_exit_seg got %h exp c7", seg_out); end
    endtask

    task automatic test_timeout();
        strobe(8'hB6);
        tick(255);
        checks++; if (seg_out !== 8'hBF || fail_count !== 2'd0) begin errors++; $display("FAIL timeout_early got seg=%h f=%0d exp seg=bf f=0", seg_out, fail_count); end
        tick(1);
        checks++; if (fail_count !== 2'd1) begin errors++; $display("FAIL timeout_fail got %0d exp 1", fail_count); end
        checks++; if (seg_out !== 8'hC7) begin errors++; $display("FAIL timeout_seg got %h exp c7", seg_out); end
        strobe(8'hB6); strobe(8'h5A);
        checks++; if (unlocked !== 1'b1 || fail_count !== 2'd0) begin errors++; $display("FAIL timeout_recover got u=%b f=%0d exp u=1 f=0", unlocked, fail_count); end
        do_relock();
    endtask

    task automatic test_timeout_vs_strobe();
        strobe(8'hB6);
        tick(255);
        strobe(8'h5A);
        checks++; if (unlocked !== 1'b1 || fail_count !== 2'd0) begin errors++; $display("FAIL strobe_beats_timeout got u=%b f=%0d exp u=1 f=0", unlocked, fail_count); end
        do_relock();
    endtask

    task automatic test_ena_freeze();
        strobe(8'hB6);
        ena = 1'b0;
        tick(1);
        checks++; if (seg_out !== 8'hFF || glow !== 8'h00) begin errors++; $display("FAIL ena_blank got seg=%h glow=%h exp seg=ff glow=00", seg_out, glow); end
        tick(200);
        strobe(8'h00);
        tick(299);
        ena = 1'b1;
        #1;
        checks++; if (seg_out !== 8'hBF || fail_count !== 2'd0) begin errors++; $display("FAIL ena_resume got seg=%h f=%0d exp seg=bf f=0", seg_out, fail_count); end
        strobe(8'h5A);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL ena_unlock got %b exp 1", unlocked); end
        ena = 1'b0;
        #1;
        checks++; if (glow !== 8'h00 || seg_out !== 8'hFF || unlocked !== 1'b1) begin errors++; $display("FAIL ena_unlocked_blank got glow=%h seg=%h u=%b exp 00 ff 1", glow, seg_out, unlocked); end
        ena = 1'b1;
        do_relock();
    endtask

    task automatic test_reset_mid_entry();
        strobe(8'hB6);
        strobe(8'h11);
        strobe(8'hB6);
        #2 rst = 1'b1;
        #1;
        checks++; if (seg_out !== 8'hC7 || fail_count !== 2'd0) begin errors++; $display("FAIL reset_mid_entry got seg=%h f=%0d exp seg=c7 f=0", seg_out, fail_count); end
        tick(1);
        rst = 1'b0;
        tick(1);
        strobe(8'hB6); strobe(8'h5A);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL reset_then_unlock got %b exp 1", unlocked); end
    endtask

    task automatic test_auto_relock();
`ifdef SENTINEL_AUTO_RELOCK_EN
        tick(4095);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL auto_relock_hold got %b exp 1", unlocked); end
        tick(1);
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL auto_relock_drop got %b exp 0", unlocked); end
`else
        tick(10000);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_persist got %b exp 1", unlocked); end
`endif
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_relock_priority();
        test_lockout();
        test_timeout();
        test_timeout_vs_strobe();
        test_ena_freeze();
        test_reset_mid_entry();
        test_auto_relock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
